// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch (IF)
//   and the MEM stage. Multi-byte little-endian accesses are sequenced one
//   byte per cycle. Per-stage stall requests are produced for the stall
//   controller. A branch flush aborts an in-flight fetch.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   if_req/if_addr     fetch request (held until if_done) and byte address
//   if_done/if_inst    one-cycle completion pulse and fetched word (held)
//   mem_req/mem_we     MEM request (held until mem_done), 1 = store
//   mem_len            byte count minus one (0..3)
//   mem_addr/mem_wdata base byte address and store data (byte k at [8k+7:8k])
//   mem_done/mem_rdata one-cycle completion pulse and zero-extended load data
//   b_flag_i           branch taken: abandons an in-flight fetch
//   stall_req_if/_mem  combinational stall requests
//   ram_addr/ram_dout  registered RAM address and write data
//   ram_wr             registered RAM write strobe
//   ram_din            RAM read data, valid the cycle after its address edge
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic              b_flag_i,
  output logic              stall_req_if,
  output logic              stall_req_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t state, state_nxt;

  // cnt counts edges since acceptance (1 on the first edge after it).
  // last holds N-1, so a read ends at cnt == N+1 and a write at cnt == N.
  logic [2:0]        cnt;
  logic [1:0]        last;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wbuf;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;

  logic              idle_free;
  logic              take_mem;
  logic              take_if;
  logic              flush;
  logic              issue;
  logic              capture;
  logic              rd_end;
  logic              wr_end;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] addr_nxt;

  // Stall requests fall in the done cycle so the pipeline can advance.
  assign stall_req_if  = if_req  & ~if_done;
  assign stall_req_mem = mem_req & ~mem_done;

  always_comb begin
    // The done cycle doubles as a turnaround: nothing is accepted while a
    // done pulse is still high.
    idle_free = (state == IDLE) && !if_done && !mem_done;
    take_mem  = idle_free && mem_req;
    take_if   = idle_free && !mem_req && if_req && !b_flag_i;
    flush     = (state == IF_RD) && b_flag_i;
    issue     = cnt <= {1'b0, last};
    capture   = cnt >= 3'd2;
    rd_end    = cnt == ({1'b0, last} + 3'd2);
    wr_end    = cnt == ({1'b0, last} + 3'd1);
    // Byte captured now was addressed two edges ago: index cnt-2.
    cap_idx   = cnt[1:0] - 2'd2;
    addr_nxt  = base + ADDR_W'(cnt);
    asm_nxt   = asm_q;
    if (capture) asm_nxt[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take_mem)     state_nxt = mem_we ? MEM_WR : MEM_RD;
        else if (take_if) state_nxt = IF_RD;
      end
      IF_RD:   if (flush || rd_end) state_nxt = IDLE;
      MEM_RD:  if (rd_end)          state_nxt = IDLE;
      MEM_WR:  if (wr_end)          state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      last      <= 2'd0;
      base      <= '0;
      wbuf      <= '0;
      asm_q     <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_mem) begin
            base     <= mem_addr[ADDR_W-1:0];
            last     <= mem_len;
            wbuf     <= mem_wdata;
            asm_q    <= '0;
            cnt      <= 3'd1;
            ram_addr <= mem_addr[ADDR_W-1:0];
            ram_wr   <= mem_we;
            if (mem_we) ram_dout <= mem_wdata[7:0];
          end else if (take_if) begin
            base     <= if_addr[ADDR_W-1:0];
            last     <= 2'd3;
            asm_q    <= '0;
            cnt      <= 3'd1;
            ram_addr <= if_addr[ADDR_W-1:0];
            ram_wr   <= 1'b0;
          end
        end
        IF_RD, MEM_RD: begin
          if (flush) begin
            cnt <= 3'd0;
          end else begin
            cnt   <= cnt + 3'd1;
            asm_q <= asm_nxt;
            if (issue) ram_addr <= addr_nxt;
            // Last byte lands on the same edge as done, so publish asm_nxt.
            if (rd_end) begin
              cnt <= 3'd0;
              if (state == IF_RD) begin
                if_inst <= asm_nxt;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= asm_nxt;
                mem_done  <= 1'b1;
              end
            end
          end
        end
        MEM_WR: begin
          if (wr_end) begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            cnt      <= 3'd0;
          end else begin
            ram_addr <= addr_nxt;
            ram_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
            ram_wr   <= 1'b1;
            cnt      <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte RAM environment, transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic with flushes and resets.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, b_flag_i;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, stall_req_if, stall_req_mem, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .b_flag_i(b_flag_i), .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  // RAM environment and the model's own view of memory contents
  logic [7:0] ram_env [bit [31:0]];
  logic [7:0] shadow  [bit [31:0]];

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram_env.exists(a) ? ram_env[a] : 8'h00;
  endfunction
  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (ram_wr === 1'b1) ram_env[ram_addr] = ram_dout;
    ram_din <= env_rd(ram_addr);
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram_env[a] = v;
    shadow[a]  = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, timed by edges since
  // acceptance; read data comes from the shadow memory.
  int          cyc = 0;
  int          t0, m_n, m_kind;    // kind 0 fetch, 1 load, 2 store
  bit          m_on = 0, m_act = 0, m_addr_vld = 0;
  logic [31:0] m_base, m_wd, m_addr, m_if_inst, m_mem_rdata;
  logic [7:0]  m_dout;
  logic        m_wr, m_if_done, m_mem_done;

  always @(posedge clk) begin
    int          j;
    bit          prev_done;
    logic [31:0] acc;
    cyc++;
    m_on = 1;
    m_addr_vld = 0;
    if (rst) begin
      m_act = 0; m_addr = 0; m_dout = 0; m_wr = 0; m_addr_vld = 1;
      m_if_done = 0; m_mem_done = 0; m_if_inst = 0; m_mem_rdata = 0;
    end else begin
      prev_done  = m_if_done | m_mem_done;
      m_if_done  = 0;
      m_mem_done = 0;
      if (!m_act && !prev_done) begin
        if (mem_req) begin
          m_act = 1; m_kind = mem_we ? 2 : 1; m_base = mem_addr;
          m_n = int'(mem_len) + 1; m_wd = mem_wdata; t0 = cyc;
        end else if (if_req && !b_flag_i) begin
          m_act = 1; m_kind = 0; m_base = if_addr; m_n = 4; t0 = cyc;
        end
      end
      if (m_act) begin
        j = cyc - t0;
        if (m_kind == 0 && j > 0 && b_flag_i) begin
          m_act = 0;
        end else if (m_kind == 2) begin
          if (j < m_n) begin
            m_addr = m_base + 32'(j); m_addr_vld = 1;
            m_dout = m_wd[8*j +: 8]; m_wr = 1;
            shadow[m_addr] = m_dout;
          end else begin
            m_wr = 0; m_mem_done = 1; m_act = 0;
          end
        end else begin
          m_wr = 0;
          if (j < m_n) begin m_addr = m_base + 32'(j); m_addr_vld = 1; end
          if (j == m_n + 1) begin
            acc = 0;
            for (int i = 0; i < m_n; i++) acc[8*i +: 8] = sh_rd(m_base + 32'(i));
            if (m_kind == 0) begin m_if_inst = acc; m_if_done = 1; end
            else begin m_mem_rdata = acc; m_mem_done = 1; end
            m_act = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (m_on) begin
      chk("ram_wr", ram_wr, m_wr);
      chk("if_done", if_done, m_if_done);
      chk("mem_done", mem_done, m_mem_done);
      chk("if_inst", if_inst, m_if_inst);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      chk("stall_req_if", stall_req_if, if_req & ~m_if_done);
      chk("stall_req_mem", stall_req_mem, mem_req & ~m_mem_done);
      if (m_addr_vld) chk("ram_addr", ram_addr, m_addr);
      if (m_wr) chk("ram_dout", ram_dout, m_dout);
    end
  end

  // Per-cycle trace of the RAM port during a directed transaction
  logic [31:0] tr_a [16];
  logic        tr_w [16];
  logic [7:0]  tr_d [16];

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit got = 0;
    if_req = 1; if_addr = a; lat = 0; d = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); lat++;
      if (lat < 16) begin tr_a[lat] = ram_addr; tr_w[lat] = ram_wr; tr_d[lat] = ram_dout; end
      if (if_done) begin got = 1; d = if_inst; end
    end
    if_req = 0;
    if (!got) begin n_tests++; n_fail++; $display("FAIL fetch_timeout: no if_done within 40 cycles"); end
    @(negedge clk);
  endtask

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output int lat);
    bit got = 0;
    mem_req = 1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    lat = 0; d = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); lat++;
      if (lat < 16) begin tr_a[lat] = ram_addr; tr_w[lat] = ram_wr; tr_d[lat] = ram_dout; end
      if (mem_done) begin got = 1; d = mem_rdata; end
    end
    mem_req = 0;
    if (!got) begin n_tests++; n_fail++; $display("FAIL mem_timeout: no mem_done within 40 cycles"); end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  exp_st [4];
    int          lat, k, kmd, kid, nmd, nid, wr_seen;
    bit          st_ok;
    exp_st = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst = 1; if_req = 0; mem_req = 0; mem_we = 0; b_flag_i = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_len = 0;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wr", ram_wr, 32'h0);
    chk("rst_ram_dout", ram_dout, 32'h0);
    chk("rst_if_done", if_done, 32'h0);
    chk("rst_mem_done", mem_done, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 0;
    @(negedge clk);

    // Fetch of a known word
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h50); poke(32'h103, 8'h00);
    do_fetch(32'h100, d, lat);
    chk("fetch_data", d, 32'h00500513);
    chk("fetch_latency", lat, 6);
    for (int i = 0; i < 4; i++) chk("fetch_addr", tr_a[i+1], 32'h100 + i);
    chk("fetch_no_wr", tr_w[2], 0);

    // Word store, then read back
    do_mem(1'b1, 2'd3, 32'h2000, 32'hDEADBEEF, d, lat);
    chk("store_latency", lat, 5);
    for (int i = 0; i < 4; i++) begin
      chk("store_addr", tr_a[i+1], 32'h2000 + i);
      chk("store_dout", tr_d[i+1], exp_st[i]);
      chk("store_wr", tr_w[i+1], 1);
      chk("store_ram", env_rd(32'h2000 + i), exp_st[i]);
    end
    chk("store_wr_end", tr_w[5], 0);
    do_mem(1'b0, 2'd3, 32'h2000, 32'h0, d, lat);
    chk("load_word", d, 32'hDEADBEEF);
    chk("load_word_latency", lat, 6);

    // Byte load, zero-extended
    poke(32'h7FF, 8'h80); poke(32'h800, 8'h55);
    do_mem(1'b0, 2'd0, 32'h7FF, 32'h0, d, lat);
    chk("load_byte", d, 32'h00000080);
    chk("load_byte_latency", lat, 3);

    // Contention: MEM (2-byte load) served before IF
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_len = 2'd1; mem_addr = 32'h2000;
    k = 0; kmd = 0; kid = 0; nmd = 0; nid = 0; st_ok = 1;
    while (k < 40 && nid == 0) begin
      @(negedge clk); k++;
      if (k < 16) tr_a[k] = ram_addr;
      if (!if_done && stall_req_if !== 1'b1) st_ok = 0;
      if (mem_done) begin nmd++; kmd = k; mem_req = 0; end
      if (if_done)  begin nid++; kid = k; if_req = 0; end
    end
    repeat (4) begin @(negedge clk); if (mem_done) nmd++; if (if_done) nid++; end
    chk("cont_mem_done_cycle", kmd, 4);
    chk("cont_if_done_cycle", kid, 11);
    chk("cont_mem_done_count", nmd, 1);
    chk("cont_if_done_count", nid, 1);
    chk("cont_stall_if_held", st_ok, 1);
    chk("cont_if_addr", tr_a[6], 32'h100);
    chk("cont_mem_rdata", mem_rdata, 32'h0000BEEF);
    chk("cont_if_inst", if_inst, 32'h00500513);

    // Flush at E2 of a fetch
    if_req = 1; if_addr = 32'h100;
    @(negedge clk); @(negedge clk);
    b_flag_i = 1; if_req = 0;
    @(negedge clk);
    b_flag_i = 0;
    nid = 0; wr_seen = 0;
    repeat (8) begin @(negedge clk); if (if_done) nid++; if (ram_wr) wr_seen++; end
    chk("flush_no_done", nid, 0);
    chk("flush_no_wr", wr_seen, 0);
    poke(32'h40, 8'h93); poke(32'h41, 8'h00); poke(32'h42, 8'h10); poke(32'h43, 8'h00);
    do_fetch(32'h40, d, lat);
    chk("flush_refetch", d, 32'h00100093);
    chk("flush_refetch_latency", lat, 6);

    // Reset at E1 of a 4-byte store
    for (int i = 0; i < 4; i++) poke(32'h3000 + i, 8'h00);
    mem_req = 1; mem_we = 1; mem_len = 2'd3; mem_addr = 32'h3000; mem_wdata = 32'h11223344;
    @(negedge clk);
    chk("rststore_wr_e0", ram_wr, 1);
    rst = 1;
    @(negedge clk);
    chk("rststore_wr_off", ram_wr, 0);
    chk("rststore_mem_rdata", mem_rdata, 32'h0);
    chk("rststore_if_inst", if_inst, 32'h0);
    rst = 0; mem_req = 0;
    nmd = 0;
    repeat (6) begin @(negedge clk); if (mem_done) nmd++; end
    chk("rststore_no_done", nmd, 0);
    chk("rststore_byte0", env_rd(32'h3000), 32'h44);
    for (int i = 1; i < 4; i++) chk("rststore_untouched", env_rd(32'h3000 + i), 32'h00);

    // Address wrap-around
    poke(32'hFFFFFFFF, 8'hA5); poke(32'h0, 8'h5A);
    do_mem(1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, d, lat);
    chk("wrap_data", d, 32'h00005AA5);
    chk("wrap_addr0", tr_a[1], 32'hFFFFFFFF);
    chk("wrap_addr1", tr_a[2], 32'h0);
    chk("wrap_latency", lat, 4);

    // Randomized traffic with flushes and occasional resets
    for (int a = 0; a < 256; a++) poke(32'h1000 + a, 8'($urandom));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if (if_req && if_done) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'h1000 + $urandom_range(0, 250);
      end
      if (mem_req && mem_done) mem_req = 0;
      else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_we = 1'($urandom_range(0, 1)); mem_len = 2'($urandom_range(0, 3));
        mem_addr = 32'h1000 + $urandom_range(0, 250); mem_wdata = $urandom;
      end
      b_flag_i = ($urandom_range(0, 11) == 0);
    end
    rst = 0; b_flag_i = 0;
    repeat (12) @(negedge clk);
    if_req = 0; mem_req = 0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
